pm_axil_regs: RTL and testbench

AXI4-Lite slave register block for the PowerMonitoringIP: the responder on the S00_AXI interface that the master VIP bench drives. It holds four 32-bit read/write configuration registers at offsets 0x00–0x0C, plus four read-only measurement registers at 0x10–0x1C. The measurement registers are fed by a sample stream from the power sensor front end (accumulate, count, peak, status). It sits between the AXI interconnect and the monitoring datapath inside the IP.

---
 rtl/pm_axil_regs.sv | 211 +++++++++++++++++++++
 tb/tb_pm_axil_regs.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pm_axil_regs.sv
// AXI4-Lite register block for the power monitor: four RW config registers
// (CTRL, THRESHOLD, WINDOW, SCRATCH) and four RO measurement registers
// (ACCUM, COUNT, PEAK, STATUS) fed by the sensor sample stream.
module pm_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int SAMPLE_WIDTH       = 16
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  input  logic                              sample_valid,
  input  logic [SAMPLE_WIDTH-1:0]           sample_data,
  output logic                              irq
);

  localparam logic [2:0] IDX_CTRL    = 3'd0;
  localparam logic [2:0] IDX_THRESH  = 3'd1;
  localparam logic [2:0] IDX_WINDOW  = 3'd2;
  localparam logic [2:0] IDX_SCRATCH = 3'd3;
  localparam logic [2:0] IDX_ACCUM   = 3'd4;
  localparam logic [2:0] IDX_COUNT   = 3'd5;
  localparam logic [2:0] IDX_PEAK    = 3'd6;
  localparam logic [2:0] IDX_STATUS  = 3'd7;

  // Saturating accumulate of an unsigned sample into a 32-bit sum.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [SAMPLE_WIDTH-1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Byte-lane merge of write data into an existing register value.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  logic                    awready_q, awready_d;
  logic                    bvalid_q,  bvalid_d;
  logic                    arready_q, arready_d;
  logic                    rvalid_q,  rvalid_d;
  logic [31:0]             rdata_q,   rdata_d;
  logic                    irq_q,     irq_d;
  logic [31:0]             ctrl_q,    ctrl_d;
  logic [31:0]             thresh_q,  thresh_d;
  logic [31:0]             window_q,  window_d;
  logic [31:0]             scratch_q, scratch_d;
  logic [31:0]             accum_q,   accum_d;
  logic [31:0]             count_q,   count_d;
  logic [SAMPLE_WIDTH-1:0] peak_q,    peak_d;
  logic [1:0]              status_q,  status_d;

  logic        wr_commit, rd_commit, clear, accept;
  logic [2:0]  wr_idx, rd_idx;
  logic [31:0] rd_mux, count_inc;
  logic        unused;

  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign irq           = irq_q;

  // Read-side register mux; reads see pre-edge values, giving a snapshot.
  always_comb begin
    rd_idx = S_AXI_ARADDR[4:2];
    rd_mux = 32'h0;
    case (rd_idx)
      IDX_CTRL:    rd_mux = ctrl_q;
      IDX_THRESH:  rd_mux = thresh_q;
      IDX_WINDOW:  rd_mux = window_q;
      IDX_SCRATCH: rd_mux = scratch_q;
      IDX_ACCUM:   rd_mux = accum_q;
      IDX_COUNT:   rd_mux = count_q;
      IDX_PEAK:    rd_mux = 32'(peak_q);
      IDX_STATUS:  rd_mux = {30'h0, status_q};
      default:     rd_mux = 32'h0;
    endcase
  end

  // AXI handshakes: AW and W accepted together as one-cycle ready pulses.
  always_comb begin
    wr_idx    = S_AXI_AWADDR[4:2];
    wr_commit = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
    rd_commit = arready_q & S_AXI_ARVALID;
    awready_d = ~awready_q & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
    arready_d = ~arready_q & S_AXI_ARVALID & ~rvalid_q;

    bvalid_d = bvalid_q;
    if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
    if (wr_commit)                bvalid_d = 1'b1;

    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
    if (rd_commit) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
    end
  end

  // Config writes, sample accumulation and clear (clear overrides a sample).
  always_comb begin
    ctrl_d    = ctrl_q;
    thresh_d  = thresh_q;
    window_d  = window_q;
    scratch_d = scratch_q;
    accum_d   = accum_q;
    count_d   = count_q;
    peak_d    = peak_q;
    status_d  = status_q;
    count_inc = count_q + 32'd1;

    clear  = wr_commit && (wr_idx == IDX_CTRL) && S_AXI_WSTRB[0] && S_AXI_WDATA[1];
    accept = sample_valid & ctrl_q[0] & ~status_q[1];

    if (wr_commit) begin
      case (wr_idx)
        IDX_CTRL:    ctrl_d    = strb_merge(ctrl_q, S_AXI_WDATA, S_AXI_WSTRB) & ~32'h2;
        IDX_THRESH:  thresh_d  = strb_merge(thresh_q, S_AXI_WDATA, S_AXI_WSTRB);
        IDX_WINDOW:  window_d  = strb_merge(window_q, S_AXI_WDATA, S_AXI_WSTRB);
        IDX_SCRATCH: scratch_d = strb_merge(scratch_q, S_AXI_WDATA, S_AXI_WSTRB);
        default:     ;
      endcase
    end

    if (accept) begin
      accum_d = sat_add(accum_q, sample_data);
      count_d = count_inc;
      if (sample_data > peak_q) peak_d = sample_data;
      if (32'(sample_data) > thresh_q) status_d[0] = 1'b1;
      if ((window_q != 32'h0) && (count_inc == window_q)) status_d[1] = 1'b1;
    end

    if (clear) begin
      accum_d  = 32'h0;
      count_d  = 32'h0;
      peak_d   = '0;
      status_d = 2'b00;
    end

    irq_d = status_q[1] & ctrl_q[2];
  end

  // State registers; everything returns to zero on reset.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
      irq_q     <= 1'b0;
      ctrl_q    <= 32'h0;
      thresh_q  <= 32'h0;
      window_q  <= 32'h0;
      scratch_q <= 32'h0;
      accum_q   <= 32'h0;
      count_q   <= 32'h0;
      peak_q    <= '0;
      status_q  <= 2'b00;
    end else begin
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
      ctrl_q    <= ctrl_d;
      thresh_q  <= thresh_d;
      window_q  <= window_d;
      scratch_q <= scratch_d;
      accum_q   <= accum_d;
      count_q   <= count_d;
      peak_q    <= peak_d;
      status_q  <= status_d;
    end
  end

endmodule

// File: tb/tb_pm_axil_regs.sv
// Directed bench for pm_axil_regs: register table plus hand-written
// sequences for sampling, clear, back-pressure and reset.
module tb_pm_axil_regs;

  logic        ACLK;
  logic        ARESET;
  logic [4:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [4:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic        irq;

  pm_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5), .SAMPLE_WIDTH(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .sample_valid(sample_valid), .sample_data(sample_data), .irq(irq)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t tab1 [20];
  vec_t tab2 [4];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic wait_awready();
    int n = 0;
    while (!S_AXI_AWREADY && n < 16) begin
      @(posedge ACLK); #1;
      n++;
    end
    check("aw_w_ready", {30'h0, S_AXI_AWREADY, S_AXI_WREADY}, 32'h3);
  endtask

  task automatic wait_arready();
    int n = 0;
    while (!S_AXI_ARREADY && n < 16) begin
      @(posedge ACLK); #1;
      n++;
    end
    check("arready", {31'h0, S_AXI_ARREADY}, 32'h1);
  endtask

  // Full write with BREADY high; optionally drives a sample in the commit cycle.
  task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                           input logic [3:0] s, input bit samp);
    S_AXI_AWADDR  = a;
    S_AXI_WDATA   = d;
    S_AXI_WSTRB   = s;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    S_AXI_BREADY  = 1'b1;
    wait_awready();
    if (samp) begin
      sample_valid = 1'b1;
      sample_data  = 16'd999;
    end
    @(posedge ACLK); #1;
    sample_valid  = 1'b0;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    check("bvalid_set", {31'h0, S_AXI_BVALID}, 32'h1);
    check("bresp", {30'h0, S_AXI_BRESP}, 32'h0);
    @(posedge ACLK); #1;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
    S_AXI_ARADDR  = a;
    S_AXI_ARVALID = 1'b1;
    S_AXI_RREADY  = 1'b1;
    wait_arready();
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    check("rvalid_set", {31'h0, S_AXI_RVALID}, 32'h1);
    check("rresp", {30'h0, S_AXI_RRESP}, 32'h0);
    d = S_AXI_RDATA;
    @(posedge ACLK); #1;
  endtask

  task automatic rd_chk(input string nm, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(a, d);
    check(nm, d, exp);
  endtask

  task automatic send_sample(input logic [15:0] v);
    sample_data  = v;
    sample_valid = 1'b1;
    @(posedge ACLK); #1;
    sample_valid = 1'b0;
  endtask

  task automatic apply(input vec_t v, input int i);
    logic [31:0] d;
    if (v.wr) axi_write(v.addr, v.data, v.strb, 1'b0);
    else begin
      axi_read(v.addr, d);
      check($sformatf("vec_rd%0d", i), d, v.exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    tab1[0]  = '{1'b1, 5'h00, 32'h0000_0001, 4'hF, 32'h0};
    tab1[1]  = '{1'b1, 5'h04, 32'h0000_0002, 4'hF, 32'h0};
    tab1[2]  = '{1'b1, 5'h08, 32'h0000_0003, 4'hF, 32'h0};
    tab1[3]  = '{1'b1, 5'h0C, 32'h0000_0004, 4'hF, 32'h0};
    tab1[4]  = '{1'b0, 5'h00, 32'h0,         4'h0, 32'h0000_0001};
    tab1[5]  = '{1'b0, 5'h04, 32'h0,         4'h0, 32'h0000_0002};
    tab1[6]  = '{1'b0, 5'h08, 32'h0,         4'h0, 32'h0000_0003};
    tab1[7]  = '{1'b0, 5'h0C, 32'h0,         4'h0, 32'h0000_0004};
    tab1[8]  = '{1'b1, 5'h0C, 32'h0000_0000, 4'hF, 32'h0};
    tab1[9]  = '{1'b1, 5'h0C, 32'hAABB_CCDD, 4'h5, 32'h0};
    tab1[10] = '{1'b0, 5'h0C, 32'h0,         4'h0, 32'h00BB_00DD};
    tab1[11] = '{1'b0, 5'h0E, 32'h0,         4'h0, 32'h00BB_00DD};
    tab1[12] = '{1'b1, 5'h10, 32'hFFFF_FFFF, 4'hF, 32'h0};
    tab1[13] = '{1'b0, 5'h10, 32'h0,         4'h0, 32'h0000_0000};
    tab1[14] = '{1'b1, 5'h00, 32'h0000_0003, 4'hF, 32'h0};
    tab1[15] = '{1'b0, 5'h00, 32'h0,         4'h0, 32'h0000_0001};
    tab1[16] = '{1'b1, 5'h04, 32'd100,       4'hF, 32'h0};
    tab1[17] = '{1'b1, 5'h08, 32'd3,         4'hF, 32'h0};
    tab1[18] = '{1'b1, 5'h04, 32'hFFFF_FFFF, 4'h0, 32'h0};
    tab1[19] = '{1'b0, 5'h04, 32'h0,         4'h0, 32'd100};
    tab2[0]  = '{1'b0, 5'h10, 32'h0, 4'h0, 32'd220};
    tab2[1]  = '{1'b0, 5'h14, 32'h0, 4'h0, 32'd3};
    tab2[2]  = '{1'b0, 5'h18, 32'h0, 4'h0, 32'd150};
    tab2[3]  = '{1'b0, 5'h1C, 32'h0, 4'h0, 32'h3};

    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b0; S_AXI_ARADDR = '0; S_AXI_ARPROT = '0;
    S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    sample_valid = 1'b0; sample_data = '0;

    #3;
    check("reset_ctl_outs", {23'h0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP,
                             S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RRESP, irq}, 32'h0);
    check("reset_rdata", S_AXI_RDATA, 32'h0);
    #9 ARESET = 1'b0;
    @(posedge ACLK); #1;
    rd_chk("reset_ctrl", 5'h00, 32'h0);
    rd_chk("reset_status", 5'h1C, 32'h0);

    for (int i = 0; i < 20; i++) apply(tab1[i], i);

    // Window of 3 with threshold 100; the fourth sample must be ignored.
    send_sample(16'd50);
    send_sample(16'd150);
    send_sample(16'd20);
    send_sample(16'd70);
    for (int i = 0; i < 4; i++) apply(tab2[i], 20 + i);
    check("irq_disabled", {31'h0, irq}, 32'h0);

    // Clear together with a simultaneous sample; irq enable set by the same write.
    axi_write(5'h00, 32'h0000_0007, 4'hF, 1'b1);
    rd_chk("clr_accum",  5'h10, 32'h0);
    rd_chk("clr_count",  5'h14, 32'h0);
    rd_chk("clr_peak",   5'h18, 32'h0);
    rd_chk("clr_status", 5'h1C, 32'h0);
    rd_chk("clr_ctrl",   5'h00, 32'h5);
    check("irq_after_clr", {31'h0, irq}, 32'h0);
    send_sample(16'd10);
    send_sample(16'd20);
    send_sample(16'd30);
    check("irq_lag", {31'h0, irq}, 32'h0);
    @(posedge ACLK); #1;
    check("irq_set", {31'h0, irq}, 32'h1);
    rd_chk("win2_accum",  5'h10, 32'd60);
    rd_chk("win2_status", 5'h1C, 32'h2);

    // WINDOW=0 is unlimited: no window_done after several samples.
    axi_write(5'h08, 32'h0, 4'hF, 1'b0);
    axi_write(5'h00, 32'h0000_0003, 4'hF, 1'b0);
    for (int i = 0; i < 5; i++) send_sample(16'd5);
    rd_chk("unl_count",  5'h14, 32'd5);
    rd_chk("unl_status", 5'h1C, 32'h0);
    rd_chk("unl_peak",   5'h18, 32'd5);

    // BREADY held low: response held, second write blocked until released.
    S_AXI_AWADDR = 5'h0C; S_AXI_WDATA = 32'h11; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    wait_awready();
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_WDATA = 32'h22; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge ACLK); #1;
      check("bp_bvalid_hold", {31'h0, S_AXI_BVALID}, 32'h1);
      check("bp_awready_low", {31'h0, S_AXI_AWREADY}, 32'h0);
    end
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    check("bp_bvalid_drop", {31'h0, S_AXI_BVALID}, 32'h0);
    wait_awready();
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    check("bp_bvalid2", {31'h0, S_AXI_BVALID}, 32'h1);
    @(posedge ACLK); #1;
    rd_chk("bp_scratch", 5'h0C, 32'h22);

    // Reset while a read response is pending.
    S_AXI_ARADDR = 5'h0C; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    wait_arready();
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    check("rst_rvalid_pend", {31'h0, S_AXI_RVALID}, 32'h1);
    @(posedge ACLK); #1;
    check("rst_rvalid_hold", {31'h0, S_AXI_RVALID}, 32'h1);
    check("rst_rdata_hold", S_AXI_RDATA, 32'h22);
    #2 ARESET = 1'b1;
    #1;
    check("rst_rvalid_drop", {31'h0, S_AXI_RVALID}, 32'h0);
    check("rst_rdata_zero", S_AXI_RDATA, 32'h0);
    #3 ARESET = 1'b0;
    S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    check("post_rst_rvalid", {31'h0, S_AXI_RVALID}, 32'h0);
    rd_chk("post_rst_ctrl", 5'h00, 32'h0);
    rd_chk("post_rst_scratch", 5'h0C, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
